pad_link_tx: RTL and testbench

Slave-side serial transmitter for the two-board controller link. It samples the local five player-2 buttons (up, down, left, right, attack) on a send strobe and serializes them as one framed packet on a single pin. The packet carries a rolling sequence number. The master board's link receiver recovers the buttons from this pin and feeds them to its player-2 movement handler. Sits between the slave board's raw button inputs and one JXADC output pin.

---
 rtl/pad_link_pkg.sv | 37 +++
 rtl/pad_link_tx_if.sv | 15 +
 rtl/pad_link_baud.sv | 29 ++
 rtl/pad_link_tx.sv | 141 ++++++++++++++
 tb/tb_pad_link_tx.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/pad_link_pkg.sv
// Shared definitions for the two-board pad link (tx and rx sides).
// Optional feature macro: PAD_LINK_PARITY_EN adds an even-parity bit before stop.
package pad_link_pkg;

  localparam int PAD_LINK_DATA_BITS    = 5;
  localparam int PAD_LINK_SEQ_BITS     = 2;
  localparam int PAD_LINK_PAYLOAD_BITS = PAD_LINK_DATA_BITS + PAD_LINK_SEQ_BITS;

`ifdef PAD_LINK_PARITY_EN
  localparam int PAD_LINK_FRAME_BITS = 1 + PAD_LINK_PAYLOAD_BITS + 1 + 1;
`else
  localparam int PAD_LINK_FRAME_BITS = 1 + PAD_LINK_PAYLOAD_BITS + 1;
`endif

  // Button bit positions within the 5-bit button word.
  localparam int BTN_DOWN   = 0;
  localparam int BTN_UP     = 1;
  localparam int BTN_LEFT   = 2;
  localparam int BTN_RIGHT  = 3;
  localparam int BTN_ATTACK = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_SEQ    = 3'd3,
`ifdef PAD_LINK_PARITY_EN
    ST_PARITY = 3'd4,
`endif
    ST_STOP   = 3'd5
  } pad_link_state_t;

  function automatic logic even_parity(input logic [PAD_LINK_PAYLOAD_BITS-1:0] payload);
    return ^payload;
  endfunction

endpackage

// File: rtl/pad_link_tx_if.sv
// Handshake and serial-line bundle between the button logic and the pad link transmitter.
interface pad_link_tx_if;
  import pad_link_pkg::*;

  logic                            send_req;
  logic [PAD_LINK_DATA_BITS-1:0]   buttons;
  logic                            tx;
  logic                            busy;
  logic                            done;
  logic                            dropped;
  logic [PAD_LINK_SEQ_BITS-1:0]    seq;

  modport master (output send_req, buttons, input tx, busy, done, dropped, seq);
  modport slave  (input send_req, buttons, output tx, busy, done, dropped, seq);
endinterface

// File: rtl/pad_link_baud.sv
// Bit-period counter: wraps every CLKS_PER_BIT cycles, restarts on clr.
module pad_link_baud #(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  output logic bit_end,
  output logic bit_near
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] NEAR = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (!reset_n || clr)
      cnt_reg <= '0;
    else if (cnt_reg == LAST)
      cnt_reg <= '0;
    else
      cnt_reg <= cnt_reg + 1'b1;
  end

  // bit_near flags the cycle before the last one so callers can register a last-cycle pulse.
  assign bit_end  = (cnt_reg == LAST);
  assign bit_near = (cnt_reg == NEAR);
endmodule

// File: rtl/pad_link_tx.sv
// Player-2 button frame transmitter: start, 5 data, 2 seq, [parity], stop; LSB first.
// Optional feature macro: PAD_LINK_PARITY_EN.
module pad_link_tx
  import pad_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic          clk,
  input  logic          reset_n,
  pad_link_tx_if.slave  link
);
  localparam logic [2:0] DATA_LAST = 3'(PAD_LINK_DATA_BITS - 1);
  localparam logic [2:0] SEQ_LAST  = 3'(PAD_LINK_PAYLOAD_BITS - 1);

  pad_link_state_t                  state_reg, state_next;
  logic [PAD_LINK_PAYLOAD_BITS-1:0] shreg_reg, shreg_next;
  logic [2:0]                       idx_reg, idx_next;
  logic [PAD_LINK_SEQ_BITS-1:0]     seq_reg, seq_next;
  logic                             tx_reg, tx_next;
  logic                             busy_reg, busy_next;
  logic                             done_reg, done_next;
  logic                             dropped_reg, dropped_next;
  logic                             baud_clr, bit_end, bit_near;
`ifdef PAD_LINK_PARITY_EN
  logic                             par_reg, par_next;
`endif

  pad_link_baud #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (baud_clr),
    .bit_end  (bit_end),
    .bit_near (bit_near)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg   <= ST_IDLE;
      shreg_reg   <= '0;
      idx_reg     <= '0;
      seq_reg     <= '0;
      tx_reg      <= 1'b1;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      dropped_reg <= 1'b0;
`ifdef PAD_LINK_PARITY_EN
      par_reg     <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      shreg_reg   <= shreg_next;
      idx_reg     <= idx_next;
      seq_reg     <= seq_next;
      tx_reg      <= tx_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      dropped_reg <= dropped_next;
`ifdef PAD_LINK_PARITY_EN
      par_reg     <= par_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    shreg_next = shreg_reg;
    idx_next   = idx_reg;
    seq_next   = seq_reg;
    baud_clr   = 1'b0;
`ifdef PAD_LINK_PARITY_EN
    par_next   = par_reg;
`endif

    case (state_reg)
      ST_IDLE: begin
        if (link.send_req) begin
          state_next = ST_START;
          seq_next   = seq_reg + 2'd1;
          shreg_next = {seq_next, link.buttons};
          idx_next   = '0;
          baud_clr   = 1'b1;
`ifdef PAD_LINK_PARITY_EN
          par_next   = even_parity({seq_next, link.buttons});
`endif
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_next = ST_DATA;
          idx_next   = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shreg_next = shreg_reg >> 1;
          idx_next   = idx_reg + 3'd1;
          if (idx_reg == DATA_LAST)
            state_next = ST_SEQ;
        end
      end
      ST_SEQ: begin
        if (bit_end) begin
          shreg_next = shreg_reg >> 1;
          idx_next   = idx_reg + 3'd1;
          if (idx_reg == SEQ_LAST)
`ifdef PAD_LINK_PARITY_EN
            state_next = ST_PARITY;
`else
            state_next = ST_STOP;
`endif
        end
      end
`ifdef PAD_LINK_PARITY_EN
      ST_PARITY: if (bit_end) state_next = ST_STOP;
`endif
      ST_STOP:  if (bit_end) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase

    // Outputs are registered from the next state so every pin is a flop.
    tx_next = 1'b1;
    case (state_next)
      ST_START:        tx_next = 1'b0;
      ST_DATA, ST_SEQ: tx_next = shreg_next[0];
`ifdef PAD_LINK_PARITY_EN
      ST_PARITY:       tx_next = par_next;
`endif
      default:         tx_next = 1'b1;
    endcase

    busy_next    = (state_next != ST_IDLE);
    done_next    = (state_reg == ST_STOP) && bit_near;
    dropped_next = link.send_req && (state_reg != ST_IDLE);
  end

  assign link.tx      = tx_reg;
  assign link.busy    = busy_reg;
  assign link.done    = done_reg;
  assign link.dropped = dropped_reg;
  assign link.seq     = seq_reg;
endmodule

// File: tb/tb_pad_link_tx.sv
// Randomized scoreboard bench for pad_link_tx with a frame-level reference model.
module tb_pad_link_tx;
  localparam int C = 4;
`ifdef PAD_LINK_PARITY_EN
  localparam int F = 10;
`else
  localparam int F = 9;
`endif

  typedef struct {
    int         k;
    logic [9:0] bits;
    logic [1:0] seq;
  } frame_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pad_link_tx_if link();

  pad_link_tx #(.CLKS_PER_BIT(C)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .link    (link)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  frame_t exp_q[$];
  int     drop_q[$];
  int     total = 0;
  int     bad = 0;
  int     model_seq = 0;
  int     free_edge = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  // Frame bits in transmission order, straight from the frame layout rules.
  function automatic logic [9:0] make_frame(input logic [4:0] b, input int s);
    logic [9:0] bits;
    int ones;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 5; i++) bits[1+i] = b[i];
    for (int j = 0; j < 2; j++) bits[6+j] = 1'((s >> j) & 1);
    ones = $countones(b) + $countones(2'(s));
`ifdef PAD_LINK_PARITY_EN
    bits[8] = 1'(ones % 2);
`endif
    bits[F-1] = 1'b1;
    return bits;
  endfunction

  // One cycle of stimulus starting at a negedge; the request is sampled at the next posedge.
  task automatic step(input logic req, input logic [4:0] b);
    int k;
    link.send_req = req;
    link.buttons  = b;
    if (req) begin
      k = cyc + 1;
      if (k >= free_edge) begin
        frame_t f;
        model_seq = (model_seq + 1) % 4;
        f.k    = k;
        f.bits = make_frame(b, model_seq);
        f.seq  = 2'(model_seq);
        exp_q.push_back(f);
        free_edge = k + F * C + 1;
      end else begin
        drop_q.push_back(k + 1);
      end
    end
    @(negedge clk);
    link.send_req = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    exp_q.delete();
    drop_q.delete();
    model_seq = 0;
    repeat (n) @(negedge clk);
    reset_n = 1'b1;
    free_edge = 0;
  endtask

  task automatic idle(input int n, input logic [4:0] b);
    repeat (n) step(1'b0, b);
  endtask

  // Monitor: e is the edge at which the currently visible outputs would be sampled.
  int     e;
  logic   exp_tx, exp_busy;
  frame_t mf;
  int     md;
  always @(posedge clk) begin
    #1;
    e = cyc + 1;
    if (exp_q.size() > 0 && e > exp_q[0].k + F * C) begin
      mf = exp_q.pop_front();
      check("done_missing", 0, 1);
    end
    while (drop_q.size() > 0 && e > drop_q[0]) begin
      md = drop_q.pop_front();
      check("dropped_missing", 0, md);
    end
    exp_tx = 1'b1;
    exp_busy = 1'b0;
    if (exp_q.size() > 0 && e >= exp_q[0].k + 1) begin
      exp_tx = exp_q[0].bits[(e - exp_q[0].k - 1) / C];
      exp_busy = 1'b1;
      if (e == exp_q[0].k + 1) check("seq_at_start", int'(link.seq), int'(exp_q[0].seq));
    end
    check("tx", int'(link.tx), int'(exp_tx));
    check("busy", int'(link.busy), int'(exp_busy));
    if (link.done) begin
      if (exp_q.size() == 0) check("done_unexpected", 1, 0);
      else begin
        mf = exp_q.pop_front();
        check("done_cycle", e, mf.k + F * C);
        check("seq_at_done", int'(link.seq), int'(mf.seq));
      end
    end
    if (link.dropped) begin
      if (drop_q.size() == 0) check("dropped_unexpected", 1, 0);
      else begin
        md = drop_q.pop_front();
        check("dropped_cycle", e, md);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [4:0] b;
    link.send_req = 1'b0;
    link.buttons  = '0;

    // Reset held five cycles, then a quiet line.
    do_reset(5);
    idle(20, 5'b00000);
    check("idle_seq", int'(link.seq), 0);
    check("idle_tx", int'(link.tx), 1);
    check("idle_busy", int'(link.busy), 0);

    // Directed frame with the documented button pattern.
    step(1'b1, 5'b10110);
    idle(F * C + 2, 5'b10110);
    check("directed_seq", int'(link.seq), 1);

    // Four back-to-back frames from reset, each in the first idle slot.
    do_reset(2);
    for (int n = 0; n < 4; n++) begin
      while (cyc + 1 < free_edge) step(1'b0, 5'($urandom));
      step(1'b1, 5'($urandom));
      check("b2b_model_seq", int'(link.seq), (n + 1) % 4);
    end
    idle(F * C + 2, 5'b0);
    check("b2b_wrap_seq", int'(link.seq), 0);

    // Requests mid-frame and coincident with done are dropped.
    b = 5'b01011;
    step(1'b1, b);
    idle(10, b);
    step(1'b1, 5'b11111);
    while (cyc + 1 < free_edge - 1) step(1'b0, b);
    step(1'b1, 5'b00000);
    idle(3, b);
    check("drop_seq_unchanged", int'(link.seq), 1);

    // Buttons toggle every cycle during a frame.
    step(1'b1, 5'b10011);
    for (int n = 0; n < F * C + 2; n++) step(1'b0, 5'($urandom));

    // Reset during bit 3, then a clean frame.
    step(1'b1, 5'b01101);
    idle(3 * C + 1, 5'b01101);
    do_reset(1);
    check("midreset_tx", int'(link.tx), 1);
    check("midreset_busy", int'(link.busy), 0);
    check("midreset_seq", int'(link.seq), 0);
    idle(2, 5'b0);
    step(1'b1, 5'b00110);
    idle(F * C + 2, 5'b0);
    check("post_reset_seq", int'(link.seq), 1);

    // Randomized frames, gaps and stray requests.
    for (int it = 0; it < 25; it++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      while (cyc + 1 < free_edge + gap) step(($urandom_range(0, 15) == 0), 5'($urandom));
      step(1'b1, 5'($urandom));
    end
    idle(F * C + 5, 5'b0);
    check("scoreboard_frames_left", exp_q.size(), 0);
    check("scoreboard_drops_left", drop_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
